seq_detector_param: RTL and testbench

- Parametrised serial sequence detector: generalises the fixed-pattern Moore detectors to a run-time-programmable pattern of 1..MAX_LEN bits.
- Selectable overlapping or non-overlapping detection, sample-enable gating, a registered Moore match flag and a saturating match counter.
- Sits on a 1-bit serial input stream as a reusable pattern-spotting front end for framing and sync-word logic.

---
 rtl/seq_detector_param.sv | 80 ++++++++
 tb/tb_seq_detector_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector (1..MAX_LEN bits) with overlap
// select, sample-enable gating, registered Moore match flag and saturating count.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               en,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;
    logic               load_err;

    // Only the low len bits of history and pattern take part in the compare.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
        assign len_mask[i] = (len_q > LEN_W'(i));
    end

    assign hist_next = {hist_q[MAX_LEN-2:0], x};
    assign fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    assign load_err  = (pat_len == '0) || (pat_len > LEN_W'(MAX_LEN));

    always_comb begin
        match = 1'b0;
        if (!cfg_err && (fill_inc >= len_q)
            && (((hist_next ^ pat_q) & len_mask) == '0)) begin
            match = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b1;
            z         <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b1;
        end else if (cfg_load) begin
            pat_q     <= pattern;
            len_q     <= pat_len;
            ovl_q     <= overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= load_err;
        end else if (en) begin
            hist_q <= hist_next;
            // Non-overlapping mode restarts the fill so matched bits are not reused.
            fill_q <= (match && !ovl_q) ? '0 : fill_inc;
            z      <= match;
            if (match && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; a second instance with CNT_W=2
// shares the stimulus and is checked only for counter saturation.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               reset_n;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               en;
    logic               x;
    logic               z;
    logic [7:0]         match_cnt;
    logic               cfg_err;
    logic               z2;
    logic [1:0]         match_cnt2;
    logic               cfg_err2;

    int testsRun;
    int testsFailed;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .en(en), .x(x),
        .z(z), .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .en(en), .x(x),
        .z(z2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One clock with the given enable and bit; outputs are settled on return.
    task automatic applyStimulus(input logic e, input logic b);
        @(negedge clk);
        en = e;
        x  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        en = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic doLoad(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                          input logic o);
        @(negedge clk);
        cfg_load = 1'b1;
        pattern  = p;
        pat_len  = l;
        overlap  = o;
        en       = 1'b1;
        x        = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        cfg_load = 1'b0;
        pattern  = '1;
        pat_len  = '0;
        overlap  = ~o;
        en       = 1'b0;
    endtask

    // bits[i] is the i-th bit sent; expz[i] is z after that bit.
    task automatic runStream(input string tag, input logic [31:0] bits, input int n,
                             input logic [31:0] expz);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, bits[i]);
            checkOutput($sformatf("%s.z%0d", tag, i + 1), {31'b0, z}, {31'b0, expz[i]});
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset_n  = 1'b0;
        cfg_load = 1'b0;
        pattern  = '0;
        pat_len  = '0;
        overlap  = 1'b0;
        en       = 1'b0;
        x        = 1'b0;

        doReset();
        checkOutput("reset.z", {31'b0, z}, 32'd0);
        checkOutput("reset.cnt", {24'b0, match_cnt}, 32'd0);
        checkOutput("reset.err", {31'b0, cfg_err}, 32'd1);
        runStream("reset.nomatch", 32'b1010, 4, 32'b0000);

        doLoad(8'b0110, 4'd4, 1'b1);
        checkOutput("p0110o.err", {31'b0, cfg_err}, 32'd0);
        runStream("p0110o", 32'b0110110, 7, 32'b1001000);
        checkOutput("p0110o.cnt", {24'b0, match_cnt}, 32'd2);

        doLoad(8'b0110, 4'd4, 1'b0);
        runStream("p0110n", 32'b0110110, 7, 32'b0001000);
        checkOutput("p0110n.cnt", {24'b0, match_cnt}, 32'd1);

        doLoad(8'b111, 4'd3, 1'b1);
        runStream("p111o", 32'b111111, 6, 32'b111100);
        checkOutput("p111o.cnt", {24'b0, match_cnt}, 32'd4);

        doLoad(8'b111, 4'd3, 1'b0);
        runStream("p111n", 32'b111111, 6, 32'b100100);
        checkOutput("p111n.cnt", {24'b0, match_cnt}, 32'd2);

        // Enable gating: x toggles while en=0 and must be ignored.
        doLoad(8'b0110, 4'd4, 1'b1);
        runStream("gate.a", 32'b10, 2, 32'b00);
        applyStimulus(1'b0, 1'b1);
        checkOutput("gate.hold0", {31'b0, z}, 32'd0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("gate.hold2", {31'b0, z}, 32'd0);
        runStream("gate.b", 32'b01, 2, 32'b10);
        applyStimulus(1'b0, 1'b1);
        checkOutput("gate.zhold", {31'b0, z}, 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("gate.zhold2", {31'b0, z}, 32'd1);
        checkOutput("gate.cnt", {24'b0, match_cnt}, 32'd1);

        // Reset in the middle of a stream clears everything and reverts to error state.
        doLoad(8'b0110, 4'd4, 1'b1);
        runStream("midrst.a", 32'b110, 3, 32'b000);
        doReset();
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst.z", {31'b0, z}, 32'd0);
        checkOutput("midrst.cnt", {24'b0, match_cnt}, 32'd0);
        checkOutput("midrst.err", {31'b0, cfg_err}, 32'd1);

        doLoad(8'b0, 4'd0, 1'b1);
        checkOutput("len0.err", {31'b0, cfg_err}, 32'd1);
        runStream("len0", 32'b00001111, 8, 32'b0);
        checkOutput("len0.cnt", {24'b0, match_cnt}, 32'd0);

        doLoad(8'hFF, 4'd9, 1'b1);
        checkOutput("len9.err", {31'b0, cfg_err}, 32'd1);
        runStream("len9", 32'hFFF, 12, 32'b0);

        // Full-width pattern and ignored upper pattern bits.
        doLoad(8'hA5, 4'd8, 1'b1);
        checkOutput("full.err", {31'b0, cfg_err}, 32'd0);
        runStream("full", 32'hA5, 8, 32'h80);
        doLoad(8'hF6, 4'd4, 1'b1);
        runStream("upper", 32'b0110, 4, 32'b1000);

        // Saturation on the narrow-counter instance.
        doLoad(8'b1, 4'd1, 1'b1);
        checkOutput("sat.cnt0", {30'b0, match_cnt2}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("sat.cnt%0d", i + 1), {30'b0, match_cnt2},
                        (i < 3) ? 32'(i + 1) : 32'd3);
            checkOutput($sformatf("sat.z%0d", i + 1), {31'b0, z2}, 32'd1);
        end
        checkOutput("sat.wide", {24'b0, match_cnt}, 32'd7);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
